// File: rtl/commit_trace_streamer.sv
// commit_trace_streamer: buffers retired-instruction records (seq/pc/inst/we/waddr/wdata) from commit_* in a DEPTH-entry FIFO and streams each as 4 framed words on out_valid/out_data/out_last/out_ready; overflow is sticky on a dropped record, fifo_count excludes the record being sent; clk_in rising edge, reset sync active-low
module commit_trace_streamer #(
  parameter int          DEPTH   = 8,
  parameter logic [7:0]  HDR_TAG = 8'hA5
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     commit_valid,
  input  logic [31:0]              commit_pc,
  input  logic [31:0]              commit_inst,
  input  logic                     commit_we,
  input  logic [4:0]               commit_waddr,
  input  logic [31:0]              commit_wdata,
  output logic                     out_valid,
  output logic [31:0]              out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, SEND} state_t;
  typedef struct packed {
    logic [7:0]  seq;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rec_t;
  rec_t          r_mem [DEPTH];
  rec_t          r_hold;
  rec_t          w_head;
  rec_t          w_new;
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_count;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_k;
  logic          r_valid;
  logic          r_last;
  logic          r_ovf;
  logic [31:0]   r_data;
  logic [7:0]    r_seq;
  logic          w_hs;
  logic          w_load;
  logic          w_push;
  function automatic logic [31:0] f_word(input rec_t e, input logic [1:0] k);
    return k == 2'd0 ? {HDR_TAG, e.seq, 7'b0, e.we, 3'b0, e.waddr} :
           k == 2'd1 ? e.pc : k == 2'd2 ? e.inst : e.wdata;
  endfunction
  always_comb begin
    w_head      = r_mem[r_rp];
    w_new       = '{seq: r_seq, pc: commit_pc, inst: commit_inst, we: commit_we,
                    waddr: commit_waddr, wdata: commit_we ? commit_wdata : 32'h0};
    w_hs        = r_valid && out_ready;
    w_load      = (r_count != '0) && (r_state == IDLE || (w_hs && r_k == 2'd3));
    w_push      = commit_valid && (r_count != CW'(DEPTH) || w_load);
    w_state_nxt = w_load ? SEND : (w_hs && r_k == 2'd3) ? IDLE : r_state;
  end
  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wp] <= w_new;
  end
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_state <= IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_seq   <= '0;
      r_ovf   <= 1'b0;
      r_k     <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_seq   <= r_seq + 8'(commit_valid);
      r_ovf   <= r_ovf | (commit_valid & ~w_push);
      r_count <= r_count + CW'(w_push) - CW'(w_load);
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_load) begin
        r_rp    <= r_rp + AW'(1);
        r_hold  <= w_head;
        r_k     <= '0;
        r_valid <= 1'b1;
        r_data  <= f_word(w_head, 2'd0);
        r_last  <= 1'b0;
      end else if (w_hs) begin
        r_k     <= r_k + 2'd1;
        r_valid <= r_k != 2'd3;
        r_data  <= r_k == 2'd3 ? 32'h0 : f_word(r_hold, r_k + 2'd1);
        r_last  <= r_k == 2'd2;
      end
    end
  end
  assign out_valid  = r_valid;
  assign out_data   = r_data;
  assign out_last   = r_last;
  assign overflow   = r_ovf;
  assign fifo_count = r_count;
endmodule

// File: doc/commit_trace_streamer.md
Name: commit_trace_streamer

Overview:
- Hardware counterpart of the per-cycle pc/instr/regfile trace dump: captures each retired instruction of the single-cycle CPU and emits it as a framed 32-bit word stream over a valid/ready interface (UART/JTAG bridge or host capture FIFO).
- Sits beside sccpu in sccomp_dataflow and taps the commit point: pc, inst and the register-file write port.
- Buffers bursts in a small FIFO and reports dropped records.

Parameters:
- DEPTH, 8, FIFO record entries; power of two, >= 2.
- HDR_TAG, 8'hA5, constant in header bits [31:24].

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- commit_valid  input  1  one instruction retires this cycle.
- commit_pc  input  32  pc of the retiring instruction.
- commit_inst  input  32  instruction word.
- commit_we  input  1  register-file write enable for this instruction.
- commit_waddr  input  5  destination register index.
- commit_wdata  input  32  value written.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  32  stream word.
- out_last  output  1  high on the final (4th) word of a record.
- out_ready  input  1  sink accepts the word when out_valid && out_ready.
- overflow  output  1  sticky; at least one record was dropped.
- fifo_count  output  $clog2(DEPTH)+1  records currently buffered, excluding the one being sent.

Behaviour:
- Reset (reset==0 at a clock edge):
  - FIFO emptied; serializer returns to IDLE.
  - out_valid=0, out_data=0, out_last=0, overflow=0, fifo_count=0, seq=0.
  - Reset asserted mid-record abandons that record; nothing from before reset is sent afterwards.
- Record capture:
  - On commit_valid=1, the entry {seq, pc, inst, we, waddr, we ? wdata : 0} is pushed.
  - seq is an 8-bit counter incremented on every commit_valid cycle, whether accepted or dropped, wrapping 255->0. The host detects loss from seq gaps.
- Full handling:
  - Push is accepted if fifo_count<DEPTH, or if fifo_count==DEPTH and the serializer loads a new entry from the FIFO in the same cycle.
  - Otherwise the record is dropped and overflow is set to 1; it stays 1 until reset.
- Record format, 4 words, sent in order:
  - W0 = {HDR_TAG, seq[7:0], 7'b0, we, 3'b0, waddr[4:0]}
  - W1 = pc
  - W2 = inst
  - W3 = wdata (0 when we=0), with out_last=1
- Serializer FSM:
  - IDLE -> SEND when the FIFO is non-empty; the head entry is popped into an output holding register and word index k=0.
  - In SEND, word k is presented. On handshake, k increments.
  - On the handshake of k=3: if the FIFO is non-empty, load the next entry and stay in SEND with k=0 (back-to-back, no bubble); otherwise go to IDLE.
- Stream rules:
  - out_valid, out_data and out_last are registered.
  - Once out_valid=1, out_data and out_last hold stable and out_valid stays high until a handshake. No word is retracted or reordered.
  - With out_ready held 1, a record streams in 4 consecutive cycles.
- Latency:
  - A commit at edge N into an empty FIFO with IDLE serializer gives out_valid=1 with W0 after edge N+1.
  - W3 handshake occurs no earlier than edge N+4.
- fifo_count:
  - Increments on an accepted push, decrements on a load into the serializer; both in the same cycle leave it unchanged.
  - Registered, and never exceeds DEPTH.
- Simultaneous push into an empty FIFO while IDLE: the entry is stored in that cycle and loaded into the serializer the next cycle. There is no combinational bypass.

Test Plan:
- Single record: reset, then commit pc=0x00400000, inst=0x20080005, we=1, waddr=8, wdata=5, out_ready=1 → W0=0xA5000108, W1=0x00400000, W2=0x20080005, W3=0x00000005 with out_last on W3; handshake on 4 consecutive cycles starting one cycle after the commit.
- Backpressure: same record, out_ready toggling 1,0,0,1,… → each word held stable while out_ready=0, no duplicates or skips, exactly 4 handshakes.
- Overflow: DEPTH=8, out_ready=0, 12 consecutive commits with we=0 → fifo_count=8 with 1 record in the serializer. The 10th commit sets overflow=1. After out_ready=1, seq values 0..8 are streamed, then nothing.
- Full push-while-pop: fifo_count=8, commit arriving on the same cycle as the W3 handshake → record accepted, overflow stays 0, its seq appears in order.
- Reset mid-record: reset asserted after the W1 handshake → next cycle out_valid=0 and fifo_count=0. A new commit streams W0 with seq=0.
- Seq wrap: 257 commits with out_ready=1 → the 257th record's header carries seq=0x00; every W3 with we=0 is 0.
